// File: rtl/sdi_ctrl_pkg.sv
// Shared state encoding, default parameters and small decode helpers for the SDI link sequencer.
// Pure declarations: no timing or flow control of its own.
package sdi_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RESET       = 3'd0,
        ST_WAIT_PLL    = 3'd1,
        ST_WAIT_TXDONE = 3'd2,
        ST_WAIT_RXDONE = 3'd3,
        ST_ALIGN       = 3'd4,
        ST_LOCKED      = 3'd5,
        ST_RETRY       = 3'd6,
        ST_FAULT       = 3'd7
    } state_t;

    localparam int DEF_RST_CYCLES      = 16;
    localparam int DEF_TIMEOUT_CYCLES  = 1024;
    localparam int DEF_LOCK_LINES      = 4;
    localparam int DEF_MISS_LIMIT      = 3;
    localparam int DEF_MAX_RETRY       = 7;
    localparam int DEF_LINES_PER_FRAME = 1125;
    localparam int LINE_W              = 11;

    function automatic logic tx_rst_for(input state_t s);
        return s inside {ST_RESET, ST_WAIT_PLL, ST_RETRY, ST_FAULT};
    endfunction

    function automatic logic rx_rst_for(input state_t s);
        return s inside {ST_RESET, ST_WAIT_PLL, ST_WAIT_TXDONE, ST_RETRY, ST_FAULT};
    endfunction

    // A line follows its predecessor, including the wrap from the last line back to 1.
    function automatic logic line_follows(input logic [LINE_W-1:0] prev,
                                          input logic [LINE_W-1:0] line,
                                          input logic [LINE_W-1:0] last_line);
        return (line == prev + 1'b1) || ((prev == last_line) && (line == LINE_W'(1)));
    endfunction

endpackage

// File: rtl/sdi_sync2.sv
// Two-flop level synchronizer for asynchronous status inputs; 2-cycle latency.
// No flow control: a level in, a level out.
module sdi_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/sdi_link_sequencer.sv
// GTX reset/bring-up sequencer with EAV line-continuity lock detection and bounded retries.
// Status inputs see 2-cycle sync latency; EAV strobes act the same cycle. No backpressure.
module sdi_link_sequencer
    import sdi_ctrl_pkg::*;
#(
    parameter int RST_CYCLES      = DEF_RST_CYCLES,
    parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
    parameter int LOCK_LINES      = DEF_LOCK_LINES,
    parameter int MISS_LIMIT      = DEF_MISS_LIMIT,
    parameter int MAX_RETRY       = DEF_MAX_RETRY,
    parameter int LINES_PER_FRAME = DEF_LINES_PER_FRAME
) (
    input  logic              DRP_CLK_IN,
    input  logic              RESET_N_IN,
    input  logic              PLLLKDET_IN,
    input  logic              TXRESETDONE_IN,
    input  logic              RXRESETDONE_IN,
    input  logic              RX_EAV_IN,
    input  logic [LINE_W-1:0] RX_LINE_NUM_IN,
    input  logic              RESTART_IN,
    output logic              GTXTXRESET_OUT,
    output logic              GTXRXRESET_OUT,
    output logic              LINK_UP_OUT,
    output logic              FAULT_OUT,
    output logic [2:0]        STATE_OUT,
    output logic [2:0]        RETRY_CNT_OUT
);

    localparam int TMAX = (RST_CYCLES > TIMEOUT_CYCLES) ? RST_CYCLES : TIMEOUT_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int GW   = $clog2(LOCK_LINES + 1);
    localparam int MW   = $clog2(MISS_LIMIT + 1);

    localparam logic [TW-1:0]     RST_LAST  = TW'(RST_CYCLES - 1);
    localparam logic [TW-1:0]     TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0]     LOCK_CNT  = GW'(LOCK_LINES);
    localparam logic [MW-1:0]     MISS_CNT  = MW'(MISS_LIMIT);
    localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(LINES_PER_FRAME);

    logic pll_lock, tx_done, rx_done;

    sdi_sync2 u_sync_pll (.clk(DRP_CLK_IN), .rst_n(RESET_N_IN), .d(PLLLKDET_IN),    .q(pll_lock));
    sdi_sync2 u_sync_tx  (.clk(DRP_CLK_IN), .rst_n(RESET_N_IN), .d(TXRESETDONE_IN), .q(tx_done));
    sdi_sync2 u_sync_rx  (.clk(DRP_CLK_IN), .rst_n(RESET_N_IN), .d(RXRESETDONE_IN), .q(rx_done));

    state_t              state, state_nxt;
    logic [TW-1:0]       timer;
    logic [GW-1:0]       good_cnt, good_nxt;
    logic [MW-1:0]       miss_cnt, miss_nxt;
    logic [LINE_W-1:0]   prev_line;
    logic                have_prev;
    logic [2:0]          retry_cnt, retry_inc;
    logic                tx_rst, rx_rst;
    logic                eav_good, timeout, lock_lost;

    assign eav_good  = have_prev && line_follows(prev_line, RX_LINE_NUM_IN, LAST_LINE);
    // The first line of a run counts as a run of one; a break restarts the run at the new line.
    assign good_nxt  = eav_good ? good_cnt + 1'b1 : GW'(1);
    assign miss_nxt  = miss_cnt + 1'b1;
    assign retry_inc = (retry_cnt == 3'd7) ? retry_cnt : retry_cnt + 3'd1;
    assign timeout   = (timer == TMO_LAST);
    assign lock_lost = !pll_lock &&
                       (state inside {ST_WAIT_TXDONE, ST_WAIT_RXDONE, ST_ALIGN, ST_LOCKED});

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RESET:       if (timer == RST_LAST) state_nxt = ST_WAIT_PLL;
            ST_WAIT_PLL:    if (timeout) state_nxt = ST_RETRY;
                            else if (pll_lock) state_nxt = ST_WAIT_TXDONE;
            ST_WAIT_TXDONE: if (timeout) state_nxt = ST_RETRY;
                            else if (tx_done) state_nxt = ST_WAIT_RXDONE;
            ST_WAIT_RXDONE: if (timeout) state_nxt = ST_RETRY;
                            else if (rx_done) state_nxt = ST_ALIGN;
            ST_ALIGN:       if (timeout) state_nxt = ST_RETRY;
                            else if (RX_EAV_IN && good_nxt == LOCK_CNT) state_nxt = ST_LOCKED;
            ST_LOCKED:      if (timeout && !RX_EAV_IN) state_nxt = ST_RETRY;
                            else if (RX_EAV_IN && !eav_good && miss_nxt == MISS_CNT)
                                state_nxt = ST_RETRY;
            ST_RETRY:       state_nxt = (int'(retry_inc) >= MAX_RETRY) ? ST_FAULT : ST_RESET;
            ST_FAULT:       state_nxt = ST_FAULT;
            default:        state_nxt = ST_RESET;
        endcase
        if (lock_lost)  state_nxt = ST_RETRY;
        if (RESTART_IN) state_nxt = ST_RESET;
    end

    always_ff @(posedge DRP_CLK_IN or negedge RESET_N_IN) begin
        if (!RESET_N_IN) begin
            state     <= ST_RESET;
            tx_rst    <= 1'b1;
            rx_rst    <= 1'b1;
            timer     <= '0;
            good_cnt  <= '0;
            miss_cnt  <= '0;
            prev_line <= '0;
            have_prev <= 1'b0;
            retry_cnt <= '0;
        end else begin
            state  <= state_nxt;
            tx_rst <= tx_rst_for(state_nxt);
            rx_rst <= rx_rst_for(state_nxt);

            // One timer serves the reset hold, the per-state waits and the EAV-absence watchdog.
            if (state_nxt != state || (state == ST_LOCKED && RX_EAV_IN))
                timer <= '0;
            else if (timer != {TW{1'b1}})
                timer <= timer + 1'b1;

            if (!(state inside {ST_ALIGN, ST_LOCKED})) begin
                have_prev <= 1'b0;
                good_cnt  <= '0;
            end else if (RX_EAV_IN) begin
                prev_line <= RX_LINE_NUM_IN;
                have_prev <= 1'b1;
                if (state == ST_ALIGN) good_cnt <= good_nxt;
            end

            if (state != ST_LOCKED)
                miss_cnt <= '0;
            else if (RX_EAV_IN)
                miss_cnt <= eav_good ? '0 : miss_nxt;

            if (RESTART_IN)
                retry_cnt <= '0;
            else if (state_nxt == ST_LOCKED && state != ST_LOCKED)
                retry_cnt <= '0;
            else if (state == ST_RETRY)
                retry_cnt <= retry_inc;
        end
    end

    assign STATE_OUT      = state;
    assign GTXTXRESET_OUT = tx_rst;
    assign GTXRXRESET_OUT = rx_rst;
    assign LINK_UP_OUT    = (state == ST_LOCKED);
    assign FAULT_OUT      = (state == ST_FAULT);
    assign RETRY_CNT_OUT  = retry_cnt;

endmodule
